// File: rtl/fp32_to_int32.sv
// fp32_to_int32: fp32 to signed int32 converter (FCVT.W.S) with STB/BUSY handshakes.
//   clk, rst (async active-low)
//   input_a / conv_input_STB / conv_BUSY             : operand handshake
//   output_conv / output_flags {invalid,inexact} /
//   conv_output_STB / output_module_BUSY             : result handshake
//   ROUND_MODE: 0 = round-to-nearest-even, 1 = round-toward-zero
module fp32_to_int32 #(
    parameter int ROUND_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        conv_input_STB,
    output logic        conv_BUSY,
    output logic [31:0] output_conv,
    output logic [1:0]  output_flags,
    output logic        conv_output_STB,
    input  logic        output_module_BUSY
);
    typedef enum logic [2:0] {get_a, unpack, special_cases, align, round, pack, put_z} state_t;
    state_t state, state_n;
    logic [31:0] a, a_n, acc, acc_n, z, z_n, conv_n;
    logic signed [9:0] e, e_n;
    logic [23:0] m, m_n;
    logic [4:0] cnt, cnt_n;
    logic [1:0] flags_n;
    logic s, s_n, guard, guard_n, sticky, sticky_n, left, left_n;
    logic inv, inv_n, inx, inx_n, busy_n, stb_n;
    always_comb begin
        state_n = state;
        a_n = a;
        acc_n = acc;
        z_n = z;
        e_n = e;
        m_n = m;
        s_n = s;
        cnt_n = cnt;
        guard_n = guard;
        sticky_n = sticky;
        left_n = left;
        inv_n = inv;
        inx_n = inx;
        busy_n = conv_BUSY;
        stb_n = conv_output_STB;
        conv_n = output_conv;
        flags_n = output_flags;
        case (state)
            get_a: begin
                busy_n = 1'b0;
                if (!conv_BUSY && conv_input_STB) begin
                    a_n = input_a;
                    busy_n = 1'b1;
                    state_n = unpack;
                end
            end
            unpack: begin
                s_n = a[31];
                e_n = 10'({2'b00, a[30:23]}) - 10'sd127;
                m_n = {|a[30:23], a[22:0]};
                state_n = special_cases;
            end
            special_cases: begin
                state_n = put_z;
                inv_n = 1'b1;
                inx_n = 1'b0;
                if (a[30:23] == 8'hff && a[22:0] != 23'd0) begin
                    z_n = 32'h7fff_ffff;
                end else if (a[30:23] == 8'hff) begin
                    z_n = s ? 32'h8000_0000 : 32'h7fff_ffff;
                end else if (e >= 10'sd31) begin
                    // -2^31 is the only representable value at or beyond e=31
                    z_n = s ? 32'h8000_0000 : 32'h7fff_ffff;
                    inv_n = !(s && e == 10'sd31 && a[22:0] == 23'd0);
                end else if (e < -10'sd1) begin
                    z_n = 32'd0;
                    inv_n = 1'b0;
                    inx_n = |a[30:0];
                end else begin
                    inv_n = 1'b0;
                    acc_n = {8'd0, m};
                    guard_n = 1'b0;
                    sticky_n = 1'b0;
                    left_n = e >= 10'sd23;
                    cnt_n = (e >= 10'sd23) ? 5'(e - 10'sd23) : 5'(10'sd23 - e);
                    state_n = align;
                end
            end
            align: begin
                if (cnt != 5'd0) begin
                    cnt_n = cnt - 5'd1;
                    if (left) begin
                        acc_n = acc << 1;
                    end else begin
                        sticky_n = sticky | guard;
                        guard_n = acc[0];
                        acc_n = acc >> 1;
                    end
                end else begin
                    state_n = round;
                end
            end
            round: begin
                if (ROUND_MODE == 0 && guard && (sticky || acc[0]))
                    acc_n = acc + 32'd1;
                inx_n = guard | sticky;
                state_n = pack;
            end
            pack: begin
                z_n = s ? -acc : acc;
                state_n = put_z;
            end
            put_z: begin
                // result registers load only on the edge where STB rises
                if (!conv_output_STB) begin
                    stb_n = 1'b1;
                    conv_n = z;
                    flags_n = {inv, inx};
                end else if (!output_module_BUSY) begin
                    stb_n = 1'b0;
                    state_n = get_a;
                end
            end
            default: state_n = get_a;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= get_a;
            a <= '0;
            acc <= '0;
            z <= '0;
            e <= '0;
            m <= '0;
            s <= 1'b0;
            cnt <= '0;
            guard <= 1'b0;
            sticky <= 1'b0;
            left <= 1'b0;
            inv <= 1'b0;
            inx <= 1'b0;
            conv_BUSY <= 1'b0;
            conv_output_STB <= 1'b0;
            output_conv <= '0;
            output_flags <= '0;
        end else begin
            state <= state_n;
            a <= a_n;
            acc <= acc_n;
            z <= z_n;
            e <= e_n;
            m <= m_n;
            s <= s_n;
            cnt <= cnt_n;
            guard <= guard_n;
            sticky <= sticky_n;
            left <= left_n;
            inv <= inv_n;
            inx <= inx_n;
            conv_BUSY <= busy_n;
            conv_output_STB <= stb_n;
            output_conv <= conv_n;
            output_flags <= flags_n;
        end
    end
endmodule

// File: tb/tb_fp32_to_int32.sv
// tb_fp32_to_int32: random and directed checks of both rounding modes against an arithmetic model.
module tb_fp32_to_int32;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] input_a = '0;
    logic in_stb = 1'b0;
    logic obusy = 1'b0;
    logic busy0, busy1, stb0, stb1;
    logic [31:0] conv0, conv1;
    logic [1:0] flags0, flags1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp32_to_int32 #(.ROUND_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .input_a(input_a), .conv_input_STB(in_stb),
        .conv_BUSY(busy0), .output_conv(conv0), .output_flags(flags0),
        .conv_output_STB(stb0), .output_module_BUSY(obusy));
    fp32_to_int32 #(.ROUND_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .input_a(input_a), .conv_input_STB(in_stb),
        .conv_BUSY(busy1), .output_conv(conv1), .output_flags(flags1),
        .conv_output_STB(stb1), .output_module_BUSY(obusy));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // value = 1.frac * 2^ev, rounded by comparing the discarded remainder with one half
    function automatic void model(input logic [31:0] x, input bit rtz,
                                  output logic [31:0] z, output logic [1:0] f, output int lat);
        int ev, sh;
        longint mag, q, rem, half;
        ev = int'(x[30:23]) - 127;
        lat = 3;
        if (x[30:23] == 8'hff) begin
            z = (x[22:0] != 0 || !x[31]) ? 32'h7fff_ffff : 32'h8000_0000;
            f = 2'b10;
        end else if (ev >= 31) begin
            z = x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
            f = (x[31] && ev == 31 && x[22:0] == 0) ? 2'b00 : 2'b10;
        end else if (ev < -1) begin
            z = 0;
            f = {1'b0, x[30:0] != 0};
        end else begin
            mag = longint'({1'b1, x[22:0]});
            if (ev >= 23) begin
                q = mag << (ev - 23);
                rem = 0;
                lat = 6 + ev - 23;
            end else begin
                sh = 23 - ev;
                q = mag >> sh;
                rem = mag - (q << sh);
                half = longint'(1) << (sh - 1);
                if (!rtz && (rem > half || (rem == half && q[0]))) q++;
                lat = 6 + sh;
            end
            z = x[31] ? 32'(-q) : 32'(q);
            f = {1'b0, rem != 0};
        end
    endfunction

    task automatic run(input logic [31:0] x, output logic [31:0] z0, output logic [31:0] z1,
                       output logic [1:0] f0, output logic [1:0] f1, output int lat);
        int c;
        c = 0;
        @(negedge clk);
        while ((busy0 || busy1) && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (c >= 60) chk("accept_timeout", 1, 0);
        input_a = x;
        in_stb = 1'b1;
        @(negedge clk);
        in_stb = 1'b0;
        c = 0;
        while (!stb0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) chk("stb_timeout", 1, 0);
        chk($sformatf("stb_sync %h", x), stb1, 1);
        z0 = conv0;
        z1 = conv1;
        f0 = flags0;
        f1 = flags1;
        lat = c;
        if (!obusy) begin
            @(negedge clk);
            chk($sformatf("stb_pulse %h", x), stb0, 0);
        end
    endtask

    task automatic dir(input logic [31:0] x, input logic [31:0] e0, input logic [1:0] g0,
                       input logic [31:0] e1, input logic [1:0] g1, input int el);
        logic [31:0] z0, z1;
        logic [1:0] f0, f1;
        int lat;
        run(x, z0, z1, f0, f1, lat);
        chk($sformatf("rne_z %h", x), z0, e0);
        chk($sformatf("rne_f %h", x), f0, g0);
        chk($sformatf("rtz_z %h", x), z1, e1);
        chk($sformatf("rtz_f %h", x), f1, g1);
        chk($sformatf("lat %h", x), lat, el);
    endtask

    task automatic rnd(input logic [31:0] x);
        logic [31:0] z0, z1, m0, m1;
        logic [1:0] f0, f1, g0, g1;
        int lat, l0, l1;
        run(x, z0, z1, f0, f1, lat);
        model(x, 1'b0, m0, g0, l0);
        model(x, 1'b1, m1, g1, l1);
        chk($sformatf("rnd_rne_z %h", x), z0, m0);
        chk($sformatf("rnd_rne_f %h", x), f0, g0);
        chk($sformatf("rnd_rtz_z %h", x), z1, m1);
        chk($sformatf("rnd_rtz_f %h", x), f1, g1);
        chk($sformatf("rnd_lat %h", x), lat, l0);
    endtask

    initial begin
        logic [31:0] x, z0, z1;
        logic [1:0] f0, f1;
        int lat, seen;
        repeat (3) @(negedge clk);
        chk("rst_stb", {stb0, stb1}, 0);
        chk("rst_busy", {busy0, busy1}, 0);
        chk("rst_conv", {conv0, conv1}, 0);
        chk("rst_flags", {flags0, flags1}, 0);
        rst = 1'b1;

        dir(32'h40490FDB, 3, 2'b01, 3, 2'b01, 28);
        dir(32'h3FC00000, 2, 2'b01, 1, 2'b01, 29);
        dir(32'h40200000, 2, 2'b01, 2, 2'b01, 28);
        dir(32'h40600000, 4, 2'b01, 3, 2'b01, 28);
        dir(32'hC0200000, 32'hFFFFFFFE, 2'b01, 32'hFFFFFFFE, 2'b01, 28);
        dir(32'h3F000000, 0, 2'b01, 0, 2'b01, 30);
        dir(32'h3F400000, 1, 2'b01, 0, 2'b01, 30);
        dir(32'h3F7FFFFF, 1, 2'b01, 0, 2'b01, 30);
        dir(32'hC0600000, 32'hFFFFFFFC, 2'b01, 32'hFFFFFFFD, 2'b01, 28);
        dir(32'h4B000000, 8388608, 2'b00, 8388608, 2'b00, 6);
        dir(32'h4F000000, 32'h7FFFFFFF, 2'b10, 32'h7FFFFFFF, 2'b10, 3);
        dir(32'hCF000000, 32'h80000000, 2'b00, 32'h80000000, 2'b00, 3);
        dir(32'h7FC00000, 32'h7FFFFFFF, 2'b10, 32'h7FFFFFFF, 2'b10, 3);
        dir(32'hFF800000, 32'h80000000, 2'b10, 32'h80000000, 2'b10, 3);
        dir(32'h00000001, 0, 2'b01, 0, 2'b01, 3);
        dir(32'h80000000, 0, 2'b00, 0, 2'b00, 3);
        dir(32'h4EFFFFFF, 32'h7FFFFF80, 2'b00, 32'h7FFFFF80, 2'b00, 13);

        for (int i = 0; i < 150; i++) begin
            x = $urandom;
            if (i % 4 != 0) x[30:23] = 8'($urandom_range(120, 160));
            if (i % 3 == 0) x[15:0] = '0;
            rnd(x);
        end

        // backpressure: result held, extra input ignored, handshake release timing
        obusy = 1'b1;
        run(32'h40490FDB, z0, z1, f0, f1, lat);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                input_a = 32'h41200000;
                in_stb = 1'b1;
            end else begin
                in_stb = 1'b0;
            end
            @(negedge clk);
            chk("bp_stb", stb0, 1);
            chk("bp_conv", conv0, 3);
            chk("bp_flags", flags0, 2'b01);
            chk("bp_busy", busy0, 1);
        end
        in_stb = 1'b0;
        obusy = 1'b0;
        @(negedge clk);
        chk("bp_stb_fall", stb0, 0);
        chk("bp_busy_hold", busy0, 1);
        @(negedge clk);
        chk("bp_busy_fall", busy0, 0);
        repeat (3) @(negedge clk);
        chk("bp_no_queue_stb", stb0, 0);
        chk("bp_no_queue_busy", busy0, 0);

        // asynchronous reset mid-align
        dir(32'h4EFFFFFF, 32'h7FFFFF80, 2'b00, 32'h7FFFFF80, 2'b00, 13);
        @(negedge clk);
        input_a = 32'h3F400000;
        in_stb = 1'b1;
        @(negedge clk);
        in_stb = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", busy0, 1);
        chk("pre_rst_conv", conv0, 32'h7FFFFF80);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", {busy0, busy1}, 0);
        chk("arst_stb", {stb0, stb1}, 0);
        chk("arst_conv", {conv0, conv1}, 0);
        chk("arst_flags", {flags0, flags1}, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stb0 || stb1) seen++;
        end
        chk("no_partial", seen, 0);
        dir(32'h41200000, 10, 2'b00, 10, 2'b00, 26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
